lfsr_word_gen: RTL and testbench

//  Parametrised Fibonacci LFSR random source with an on-demand word interface.

---
 rtl/lfsr_pkg.sv | 17 +
 rtl/lfsr_core.sv | 43 ++++
 rtl/lfsr_word_gen.sv | 134 +++++++++++++
 tb/tb_lfsr_word_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and default feedback masks for the LFSR random source.
package lfsr_pkg;

    // Word-generation sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    // Maximal-length Fibonacci feedback masks (bit i set => state[i] feeds the XOR).
    localparam logic [3:0]  TAPS_4  = 4'hC;
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h80200003;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register with step, seed load and zero-seed recovery.
// The feedback bit is exported so the word generator can capture the bit
// that enters the register on each step.
module lfsr_core #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'h0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state,
    output logic             fb,
    output logic             seed_fix
);

    // Feedback is the parity of the tapped state bits.
    assign fb = ^(state & TAPS);

    // Load has priority over step; a zero seed would lock the LFSR so it is
    // replaced by SEED and flagged for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SEED;
            seed_fix <= 1'b0;
        end else begin
            seed_fix <= 1'b0;
            if (load) begin
                if (seed_in == '0) begin
                    state    <= SEED;
                    seed_fix <= 1'b1;
                end else begin
                    state <= seed_in;
                end
            end else if (step) begin
                state <= {state[WIDTH-2:0], fb};
            end
        end
    end

endmodule

// File: rtl/lfsr_word_gen.sv
// LFSR random source with a serial on-demand word interface.
// Free-runs under 'en' while idle; a 'req' collects OUT_W feedback bits,
// one per clock, into rnd_out and pulses 'valid' for one cycle.
//
// Handshake: 'req' is sampled only in IDLE or DONE (busy=0). An accepted
// req raises busy on the next cycle; valid is a single-cycle pulse that
// coincides with rnd_out updating. There is no back-pressure and no
// queuing: req while busy is ignored. seed_load aborts any word in progress.
module lfsr_word_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'h0001,
    parameter int               OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] rnd_out,
    output logic [WIDTH-1:0] state_out,
    output logic             seed_fix
);

    localparam int CW = $clog2(OUT_W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OUT_W - 1);

    // Sequencer state, kept as a plain named signal so checkers can bind to it.
    fsm_t             fsm_q;
    logic [CW-1:0]    cnt;
    logic [OUT_W-1:0] rnd_sr;
    logic [OUT_W-1:0] sr_next;
    logic             fb;
    logic             step;

    // Advance in SHIFT every cycle; in IDLE only when free-running and no
    // request is being accepted. Never in DONE, never on a reseed.
    always_comb begin
        step = 1'b0;
        if (!seed_load) begin
            if (fsm_q == SHIFT) begin
                step = 1'b1;
            end else if (fsm_q == IDLE && !req && en) begin
                step = 1'b1;
            end
        end
    end

    // Next word shift-register value: the feedback bit enters at the LSB.
    generate
        if (OUT_W == 1) begin : g_sr_one
            assign sr_next = fb;
        end else begin : g_sr_multi
            assign sr_next = {rnd_sr[OUT_W-2:0], fb};
        end
    endgenerate

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (step),
        .load     (seed_load),
        .seed_in  (seed_in),
        .state    (state_out),
        .fb       (fb),
        .seed_fix (seed_fix)
    );

    // Word sequencer: counts OUT_W shift steps, publishes the word, then
    // either restarts on a held req or returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            cnt     <= '0;
            rnd_sr  <= '0;
            rnd_out <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (seed_load) begin
                fsm_q <= IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
            end else begin
                case (fsm_q)
                    IDLE: begin
                        if (req) begin
                            fsm_q <= SHIFT;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        rnd_sr <= sr_next;
                        if (cnt == CNT_LAST) begin
                            fsm_q   <= DONE;
                            cnt     <= '0;
                            rnd_out <= sr_next;
                            valid   <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    DONE: begin
                        if (req) begin
                            fsm_q <= SHIFT;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end else begin
                            fsm_q <= IDLE;
                        end
                    end
                    default: begin
                        fsm_q <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_word_gen.sv
// Bench for lfsr_word_gen: a 4-bit legacy-configuration instance checked
// cycle by cycle against a transaction-level reference, plus a default
// 16-bit instance used for the full-period check.
module tb_lfsr_word_gen;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 4-bit DUT ----------------
    logic       en4, sl4, req4;
    logic [3:0] seed4;
    logic       busy4, valid4, fix4;
    logic [3:0] rnd4, st4;

    lfsr_word_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .OUT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .seed_load(sl4), .seed_in(seed4),
        .req(req4), .busy(busy4), .valid(valid4), .rnd_out(rnd4),
        .state_out(st4), .seed_fix(fix4)
    );

    // ---------------- 16-bit default DUT ----------------
    logic        en16, sl16, req16;
    logic [15:0] seed16;
    logic        busy16, valid16, fix16;
    logic [3:0]  rnd16;
    logic [15:0] st16;

    lfsr_word_gen dut16 (
        .clk(clk), .rst_n(rst_n), .en(en16), .seed_load(sl16), .seed_in(seed16),
        .req(req16), .busy(busy16), .valid(valid16), .rnd_out(rnd16),
        .state_out(st16), .seed_fix(fix16)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // LFSR step from the rule: feedback = parity of tapped bits, shift left.
    function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [31:0] taps,
                                             input int width);
        int ones = 0;
        for (int i = 0; i < width; i++) if (s[i] && taps[i]) ones++;
        return (((s << 1) | 32'(ones % 2)) & ((32'd1 << width) - 1));
    endfunction

    // Word-level model: steps_left counts remaining bits of a word in flight.
    logic [3:0] m_state, m_acc, m_rnd;
    int         m_left;
    logic       m_valid, m_fix;
    logic [3:0] exp_q[$];

    task automatic model_reset();
        m_state = 4'h1; m_acc = 4'h0; m_rnd = 4'h0;
        m_left = 0; m_valid = 1'b0; m_fix = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        logic [3:0] nxt;
        logic       was_valid;
        nxt = 4'(ref_step(32'(m_state), 32'hC, 4));
        was_valid = m_valid;
        m_fix = 1'b0;
        m_valid = 1'b0;
        if (sl4) begin
            m_state = (seed4 == 4'h0) ? 4'h1 : seed4;
            m_fix = (seed4 == 4'h0);
            m_left = 0;
        end else if (m_left > 0) begin
            m_state = nxt;
            m_acc = 4'(((m_acc << 1) | {3'b0, nxt[0]}) & 4'hF);
            m_left--;
            if (m_left == 0) begin
                m_valid = 1'b1;
                m_rnd = m_acc;
                exp_q.push_back(m_acc);
            end
        end else if (req4) begin
            m_left = 4;
            m_acc = 4'h0;
        end else if (en4 && !was_valid) begin
            m_state = nxt;
        end
    endtask

    task automatic check_all();
        check("state", 32'(st4), 32'(m_state));
        check("busy", 32'(busy4), 32'(m_left > 0));
        check("valid", 32'(valid4), 32'(m_valid));
        check("rnd_out", 32'(rnd4), 32'(m_rnd));
        check("seed_fix", 32'(fix4), 32'(m_fix));
        if (valid4) begin
            if (exp_q.size() == 0) check("sb_word_expected", 32'd1, 32'd0);
            else check("sb_word", 32'(rnd4), 32'(exp_q.pop_front()));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic en, input logic req, input logic sl, input logic [3:0] seed);
        en4 = en; req4 = req; sl4 = sl; seed4 = seed;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // ---------------- stimulus ----------------
    int unsigned seq_tbl[16] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};
    logic [3:0]  old_word;
    int          last_v, n_v, zeros, hits, hit_at, mism;
    logic [31:0] m16;

    initial begin
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        en16 = 1'b0; sl16 = 1'b0; req16 = 1'b0; seed16 = 16'h0;
        model_reset();
        #12;
        check("rst_state", 32'(st4), 32'h1);
        check("rst_busy", 32'(busy4), 32'h0);
        check("rst_valid", 32'(valid4), 32'h0);
        check("rst_rnd", 32'(rnd4), 32'h0);
        check("rst_fix", 32'(fix4), 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // 1: free-run sequence against the legacy table
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        for (int i = 1; i < 16; i++) begin
            cycle();
            check("seq", 32'(st4), seq_tbl[i]);
            check("nonzero", 32'(st4 != 4'h0), 32'h1);
        end

        // 2: single word from state 1
        drive(1'b0, 1'b1, 1'b0, 4'h0);
        cycle();
        check("w_busy0", 32'(busy4), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("w_busy", 32'(busy4), 32'h1);
        end
        cycle();
        check("w_valid", 32'(valid4), 32'h1);
        check("w_word", 32'(rnd4), 32'h3);
        check("w_state", 32'(st4), 32'h3);
        check("w_busy_end", 32'(busy4), 32'h0);
        cycle();
        check("w_valid_pulse", 32'(valid4), 32'h0);

        // 3: req held high, valid every 5 cycles
        drive(1'b0, 1'b1, 1'b0, 4'h0);
        last_v = -1; n_v = 0;
        for (int i = 0; i < 21; i++) begin
            cycle();
            if (valid4) begin
                if (last_v >= 0) check("b2b_gap", 32'(i - last_v), 32'd5);
                last_v = i; n_v++;
            end
        end
        check("b2b_count", 32'(n_v), 32'd4);
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        repeat (6) cycle();

        // 4: reseed with zero and with a legal value
        drive(1'b0, 1'b0, 1'b1, 4'h0);
        cycle();
        check("zs_state", 32'(st4), 32'h1);
        check("zs_fix", 32'(fix4), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        cycle();
        check("zs_fix_pulse", 32'(fix4), 32'h0);
        drive(1'b0, 1'b0, 1'b1, 4'h9);
        cycle();
        check("s9_state", 32'(st4), 32'h9);
        check("s9_fix", 32'(fix4), 32'h0);

        // 5: reseed two cycles into a word aborts it
        old_word = rnd4;
        drive(1'b0, 1'b1, 1'b0, 4'h0);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        cycle();
        drive(1'b0, 1'b1, 1'b1, 4'h5);
        cycle();
        check("ab_busy", 32'(busy4), 32'h0);
        check("ab_valid", 32'(valid4), 32'h0);
        check("ab_rnd_kept", 32'(rnd4), 32'(old_word));
        check("ab_state", 32'(st4), 32'h5);
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        cycle();
        check("ab_no_valid", 32'(valid4), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 4'h0);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        repeat (5) cycle();

        // 6: asynchronous reset in the middle of a word
        drive(1'b0, 1'b1, 1'b0, 4'h0);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        cycle();
        #2 rst_n = 1'b0;
        #1;
        check("ar_state", 32'(st4), 32'h1);
        check("ar_busy", 32'(busy4), 32'h0);
        check("ar_valid", 32'(valid4), 32'h0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        cycle();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 31) == 0, 4'($urandom_range(0, 15)));
            cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        repeat (6) cycle();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        // 16-bit default: full period returns to SEED exactly once
        check("p16_start", 32'(st16), 32'h1);
        en16 = 1'b1;
        m16 = 32'h1; zeros = 0; hits = 0; hit_at = -1; mism = 0;
        for (int i = 1; i <= 65535; i++) begin
            @(posedge clk);
            m16 = ref_step(m16, 32'hB400, 16);
            #1;
            if (st16 == 16'h0) zeros++;
            if (st16 == 16'h1) begin hits++; hit_at = i; end
            if (32'(st16) != m16) mism++;
        end
        en16 = 1'b0;
        check("p16_hits", 32'(hits), 32'd1);
        check("p16_hit_at", 32'(hit_at), 32'd65535);
        check("p16_zeros", 32'(zeros), 32'd0);
        check("p16_model", 32'(mism), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
